// File: rtl/ddr_bank_sequencer_pkg.sv
// Shared types for the DDR bank sequencer: command pin encodings,
// sequencer states and a helper that slices fields out of a request address.
package ddr_pkg;

  // {RAS, CAS, WE} pin encodings
  typedef enum logic [2:0] {
    C_NOOP = 3'b111,
    C_ACTV = 3'b011,
    C_READ = 3'b101,
    C_WRTE = 3'b100,
    C_PRCH = 3'b010,
    C_ARSR = 3'b001
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACT,
    ST_RW,
    ST_REF_PRE,
    ST_REF
  } state_t;

  // Address pin that selects all-bank precharge on PRCH / auto-precharge on READ/WRTE
  localparam int unsigned A10_BIT = 10;

  // Extract `width` bits starting at `lsb` from a packed {row, bank, col} address
  function automatic logic [31:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((addr >> lsb) & mask);
  endfunction

endpackage

// File: rtl/ddr_bank_sequencer_if.sv
// Client request handshake into the bank sequencer.
interface ddr_bank_sequencer_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic              REQ_WE;

  modport master (output REQ_VALID, output REQ_ADDR, output REQ_WE, input REQ_READY);
  modport slave  (input REQ_VALID, input REQ_ADDR, input REQ_WE, output REQ_READY);
endinterface

// File: rtl/ddr_bank_sequencer_bank_table.sv
// Per-bank open-row tracking: one valid bit and one row address per bank.
module ddr_bank_table
  import ddr_pkg::*;
#(
  parameter  int unsigned ROW_W  = 13,
  parameter  int unsigned BANK_W = 2,
  localparam int unsigned NBANK  = 2**BANK_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BANK_W-1:0] lookup_bank,
  output logic              lookup_valid,
  output logic [ROW_W-1:0]  lookup_row,
  input  logic              set_en,
  input  logic [BANK_W-1:0] set_bank,
  input  logic [ROW_W-1:0]  set_row,
  input  logic              clr_en,
  input  logic [BANK_W-1:0] clr_bank,
  input  logic              clr_all,
  output logic [NBANK-1:0]  valid_mask
);

  logic [NBANK-1:0][ROW_W-1:0] rows;

  assign lookup_valid = valid_mask[lookup_bank];
  assign lookup_row   = rows[lookup_bank];

  // Open/close banks; clear-all takes priority over single-bank updates
  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_mask <= '0;
      rows       <= '0;
    end else begin
      if (clr_all) begin
        valid_mask <= '0;
      end else begin
        if (clr_en) valid_mask[clr_bank] <= 1'b0;
        if (set_en) valid_mask[set_bank] <= 1'b1;
      end
      if (set_en) rows[set_bank] <= set_row;
    end
  end

endmodule

// File: rtl/ddr_bank_sequencer.sv
// DDR command sequencer: tracks an open row per bank, issues
// PRCH/ACTV/READ/WRTE/ARSR with programmable gaps and services toggle refresh.
module ddr_bank_sequencer
  import ddr_pkg::*;
#(
  parameter  int unsigned ROW_W  = 13,
  parameter  int unsigned BANK_W = 2,
  parameter  int unsigned COL_W  = 10,
  parameter  int unsigned T_RP   = 3,
  parameter  int unsigned T_RCD  = 3,
  parameter  int unsigned T_CCD  = 2,
  parameter  int unsigned T_RFC  = 10,
  localparam int unsigned NBANK  = 2**BANK_W,
  localparam int unsigned ADDR_W = ROW_W + BANK_W + COL_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  ddr_bank_sequencer_if.slave  req,
  input  logic                 REFRESH_STROBE,
  output logic [2:0]           CMD,
  output logic [ROW_W-1:0]     CMD_ADDR,
  output logic [BANK_W-1:0]    CMD_BANK,
  output logic                 RW_STROBE,
  output logic                 RW_WRITE,
  output logic [NBANK-1:0]     OPEN_MASK
);

  localparam int unsigned CNT_W = 16;

  state_t            state, state_nxt, step;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_done;
  logic              ack, refresh_pending, accept, issue;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic [ROW_W-1:0]  cur_row;
  logic [BANK_W-1:0] cur_bank;
  logic [COL_W-1:0]  cur_col;

  logic              lk_valid;
  logic [ROW_W-1:0]  lk_row;

  cmd_t              issue_cmd;
  logic [ROW_W-1:0]  issue_addr;
  logic              issue_addr_en, issue_bank_en, issue_rw;
  logic [CNT_W-1:0]  issue_gap;
  logic              tbl_set, tbl_clr, tbl_clr_all, ack_load;

  assign wait_done       = (wait_cnt == '0);
  assign refresh_pending = ack ^ REFRESH_STROBE;
  assign req.REQ_READY   = (state == ST_IDLE) && wait_done && !refresh_pending;
  assign accept          = req.REQ_VALID && req.REQ_READY;

  // In IDLE the first command issues from the live request; later steps use the latched copy
  assign cur_addr = (state == ST_IDLE) ? req.REQ_ADDR : lat_addr;
  assign cur_we   = (state == ST_IDLE) ? req.REQ_WE   : lat_we;
  assign cur_row  = ROW_W'(addr_field(64'(cur_addr), BANK_W + COL_W, ROW_W));
  assign cur_bank = BANK_W'(addr_field(64'(cur_addr), COL_W, BANK_W));
  assign cur_col  = COL_W'(addr_field(64'(cur_addr), 0, COL_W));

  ddr_bank_table #(
    .ROW_W  (ROW_W),
    .BANK_W (BANK_W)
  ) u_table (
    .CLK          (CLK),
    .RST          (RST),
    .lookup_bank  (cur_bank),
    .lookup_valid (lk_valid),
    .lookup_row   (lk_row),
    .set_en       (tbl_set),
    .set_bank     (cur_bank),
    .set_row      (cur_row),
    .clr_en       (tbl_clr),
    .clr_bank     (cur_bank),
    .clr_all      (tbl_clr_all),
    .valid_mask   (OPEN_MASK)
  );

  // State register and gap counter
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (issue)           wait_cnt <= issue_gap;
      else if (!wait_done) wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  // Next state: `step` is the command slot acted on this cycle. IDLE resolves it
  // directly from refresh/request so the first command lands one cycle after accept.
  always_comb begin
    step = state;
    if (state == ST_IDLE && wait_done) begin
      if (refresh_pending) begin
        step = (OPEN_MASK != '0) ? ST_REF_PRE : ST_REF;
      end else if (req.REQ_VALID) begin
        if (!lk_valid)             step = ST_ACT;
        else if (lk_row == cur_row) step = ST_RW;
        else                        step = ST_PRE;
      end
    end
    issue     = (step != ST_IDLE) && wait_done;
    state_nxt = state;
    if (issue) begin
      case (step)
        ST_PRE:     state_nxt = ST_ACT;
        ST_ACT:     state_nxt = ST_RW;
        ST_RW:      state_nxt = ST_IDLE;
        ST_REF_PRE: state_nxt = ST_REF;
        ST_REF:     state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: command to issue, its pins, follow-on gap and table/refresh side effects
  always_comb begin
    issue_cmd     = C_NOOP;
    issue_addr    = '0;
    issue_addr_en = 1'b0;
    issue_bank_en = 1'b0;
    issue_rw      = 1'b0;
    issue_gap     = '0;
    tbl_set       = 1'b0;
    tbl_clr       = 1'b0;
    tbl_clr_all   = 1'b0;
    ack_load      = 1'b0;
    if (issue) begin
      case (step)
        ST_PRE: begin
          issue_cmd     = C_PRCH;
          issue_addr_en = 1'b1;
          issue_bank_en = 1'b1;
          issue_gap     = CNT_W'(T_RP - 1);
          tbl_clr       = 1'b1;
        end
        ST_ACT: begin
          issue_cmd     = C_ACTV;
          issue_addr    = cur_row;
          issue_addr_en = 1'b1;
          issue_bank_en = 1'b1;
          issue_gap     = CNT_W'(T_RCD - 1);
          tbl_set       = 1'b1;
        end
        ST_RW: begin
          issue_cmd     = cur_we ? C_WRTE : C_READ;
          issue_addr    = ROW_W'(cur_col);
          issue_addr_en = 1'b1;
          issue_bank_en = 1'b1;
          issue_rw      = 1'b1;
          issue_gap     = CNT_W'(T_CCD - 1);
        end
        ST_REF_PRE: begin
          issue_cmd              = C_PRCH;
          issue_addr[A10_BIT]    = 1'b1;
          issue_addr_en          = 1'b1;
          issue_gap              = CNT_W'(T_RP - 1);
          tbl_clr_all            = 1'b1;
        end
        ST_REF: begin
          issue_cmd = C_ARSR;
          issue_gap = CNT_W'(T_RFC - 1);
          ack_load  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request latch and refresh acknowledge
  always_ff @(posedge CLK) begin
    if (!RST) begin
      lat_addr <= '0;
      lat_we   <= 1'b0;
      ack      <= REFRESH_STROBE;
    end else begin
      if (accept) begin
        lat_addr <= req.REQ_ADDR;
        lat_we   <= req.REQ_WE;
      end
      if (ack_load) ack <= REFRESH_STROBE;
    end
  end

  // Registered command/address pins; address and bank hold when not driven
  always_ff @(posedge CLK) begin
    if (!RST) begin
      CMD       <= C_NOOP;
      CMD_ADDR  <= '0;
      CMD_BANK  <= '0;
      RW_STROBE <= 1'b0;
      RW_WRITE  <= 1'b0;
    end else begin
      CMD       <= issue_cmd;
      RW_STROBE <= issue_rw;
      RW_WRITE  <= issue_rw && cur_we;
      if (issue_addr_en) CMD_ADDR <= issue_addr;
      if (issue_bank_en) CMD_BANK <= cur_bank;
    end
  end

endmodule

// File: tb/tb_ddr_bank_sequencer.sv
// Directed bench for ddr_bank_sequencer with hand-computed command timing.
module tb_ddr_bank_sequencer;
  import ddr_pkg::*;

  localparam int unsigned ROW_W  = 13;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ADDR_W = ROW_W + BANK_W + COL_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              REFRESH_STROBE = 1'b0;
  logic [2:0]        CMD;
  logic [ROW_W-1:0]  CMD_ADDR;
  logic [BANK_W-1:0] CMD_BANK;
  logic              RW_STROBE;
  logic              RW_WRITE;
  logic [3:0]        OPEN_MASK;

  int n_tests = 0;
  int n_fail  = 0;

  ddr_bank_sequencer_if #(.ADDR_W(ADDR_W)) req_if();

  ddr_bank_sequencer #(
    .ROW_W  (ROW_W),
    .BANK_W (BANK_W),
    .COL_W  (COL_W),
    .T_RP   (3),
    .T_RCD  (3),
    .T_CCD  (2),
    .T_RFC  (10)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req            (req_if),
    .REFRESH_STROBE (REFRESH_STROBE),
    .CMD            (CMD),
    .CMD_ADDR       (CMD_ADDR),
    .CMD_BANK       (CMD_BANK),
    .RW_STROBE      (RW_STROBE),
    .RW_WRITE       (RW_WRITE),
    .OPEN_MASK      (OPEN_MASK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [ROW_W-1:0] row,
                                                input logic [BANK_W-1:0] bank,
                                                input logic [COL_W-1:0] col);
    return {row, bank, col};
  endfunction

  // One cycle: drive at the falling edge, settle, then the caller samples
  task automatic cyc(input logic v, input logic [ADDR_W-1:0] a, input logic we, input logic tog);
    @(negedge CLK);
    req_if.REQ_VALID = v;
    req_if.REQ_ADDR  = a;
    req_if.REQ_WE    = we;
    if (tog) REFRESH_STROBE = ~REFRESH_STROBE;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic hold();
    cyc(req_if.REQ_VALID, req_if.REQ_ADDR, req_if.REQ_WE, 1'b0);
  endtask

  task automatic noops(input int unsigned k, input string tag);
    for (int unsigned i = 0; i < k; i++) begin
      hold();
      check(tag, 32'(CMD), 32'(C_NOOP));
    end
  endtask

  logic [ADDR_W-1:0] hit_a [3];
  logic              hit_we [3] = '{1'b1, 1'b0, 1'b1};
  bit                exp_rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  cmd_t              exp_c [6]   = '{C_NOOP, C_WRTE, C_NOOP, C_READ, C_NOOP, C_WRTE};

  initial begin
    int idx;
    req_if.REQ_VALID = 1'b0;
    req_if.REQ_ADDR  = '0;
    req_if.REQ_WE    = 1'b0;
    hit_a[0] = mk_addr(13'd5, 2'd1, 10'd1);
    hit_a[1] = mk_addr(13'd5, 2'd1, 10'd2);
    hit_a[2] = mk_addr(13'd5, 2'd1, 10'd3);

    // Reset state
    repeat (3) idle();
    check("rst_cmd",  32'(CMD), 32'(C_NOOP));
    check("rst_addr", 32'(CMD_ADDR), 32'd0);
    check("rst_bank", 32'(CMD_BANK), 32'd0);
    check("rst_strb", 32'(RW_STROBE), 32'd0);
    check("rst_wr",   32'(RW_WRITE), 32'd0);
    check("rst_mask", 32'(OPEN_MASK), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rel_ready", 32'(req_if.REQ_READY), 32'd1);
    for (int i = 0; i < 20; i++) begin
      idle();
      check("idle_cmd",   32'(CMD), 32'(C_NOOP));
      check("idle_ready", 32'(req_if.REQ_READY), 32'd1);
      check("idle_mask",  32'(OPEN_MASK), 32'd0);
    end

    // Read row 5 bank 1 col 8 into a closed bank
    cyc(1'b1, mk_addr(13'd5, 2'd1, 10'd8), 1'b0, 1'b0);
    check("rd_ready", 32'(req_if.REQ_READY), 32'd1);
    idle();
    check("rd_actv",      32'(CMD), 32'(C_ACTV));
    check("rd_actv_addr", 32'(CMD_ADDR), 32'd5);
    check("rd_actv_bank", 32'(CMD_BANK), 32'd1);
    check("rd_mask",      32'(OPEN_MASK), 32'h2);
    check("rd_strb_lo",   32'(RW_STROBE), 32'd0);
    noops(2, "rd_gap");
    idle();
    check("rd_read",      32'(CMD), 32'(C_READ));
    check("rd_read_addr", 32'(CMD_ADDR), 32'd8);
    check("rd_read_bank", 32'(CMD_BANK), 32'd1);
    check("rd_strb",      32'(RW_STROBE), 32'd1);
    check("rd_wr",        32'(RW_WRITE), 32'd0);
    check("rd_rdy_gap",   32'(req_if.REQ_READY), 32'd0);
    idle();
    check("rd_after",     32'(CMD), 32'(C_NOOP));
    check("rd_strb_end",  32'(RW_STROBE), 32'd0);
    check("rd_rdy_back",  32'(req_if.REQ_READY), 32'd1);

    // Three back-to-back hits: one command every T_CCD cycles
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (idx < 3) cyc(1'b1, hit_a[idx], hit_we[idx], 1'b0);
      else         idle();
      check("hit_ready", 32'(req_if.REQ_READY), 32'(exp_rdy[i]));
      check("hit_cmd",   32'(CMD), 32'(exp_c[i]));
      check("hit_wr",    32'(RW_WRITE), 32'(exp_c[i] == C_WRTE));
      check("hit_mask",  32'(OPEN_MASK), 32'h2);
      if (exp_c[i] != C_NOOP) check("hit_col", 32'(CMD_ADDR), 32'((i + 1) / 2));
      if (req_if.REQ_VALID && req_if.REQ_READY) idx++;
    end
    check("hit_accepts", 32'(idx), 32'd3);

    // Row conflict: row 9 bank 1
    cyc(1'b1, mk_addr(13'd9, 2'd1, 10'd4), 1'b0, 1'b0);
    check("cf_ready", 32'(req_if.REQ_READY), 32'd1);
    idle();
    check("cf_prch",  32'(CMD), 32'(C_PRCH));
    check("cf_a10",   32'(CMD_ADDR[10]), 32'd0);
    check("cf_bank",  32'(CMD_BANK), 32'd1);
    check("cf_mask0", 32'(OPEN_MASK), 32'h0);
    noops(2, "cf_trp");
    idle();
    check("cf_actv",      32'(CMD), 32'(C_ACTV));
    check("cf_actv_addr", 32'(CMD_ADDR), 32'd9);
    check("cf_actv_bank", 32'(CMD_BANK), 32'd1);
    check("cf_mask1",     32'(OPEN_MASK), 32'h2);
    noops(2, "cf_trcd");
    idle();
    check("cf_read",      32'(CMD), 32'(C_READ));
    check("cf_read_addr", 32'(CMD_ADDR), 32'd4);
    check("cf_strb",      32'(RW_STROBE), 32'd1);

    // Refresh toggle collides with a request while bank 1 is open
    cyc(1'b1, mk_addr(13'd9, 2'd1, 10'd6), 1'b1, 1'b1);
    check("rf_blocked", 32'(req_if.REQ_READY), 32'd0);
    hold();
    check("rf_prch",  32'(CMD), 32'(C_PRCH));
    check("rf_a10",   32'(CMD_ADDR[10]), 32'd1);
    check("rf_mask",  32'(OPEN_MASK), 32'h0);
    check("rf_rdy1",  32'(req_if.REQ_READY), 32'd0);
    noops(2, "rf_trp");
    hold();
    check("rf_arsr",  32'(CMD), 32'(C_ARSR));
    check("rf_rdy2",  32'(req_if.REQ_READY), 32'd0);
    for (int i = 0; i < 8; i++) begin
      hold();
      check("rf_trfc_cmd", 32'(CMD), 32'(C_NOOP));
      check("rf_trfc_rdy", 32'(req_if.REQ_READY), 32'd0);
    end
    hold();
    check("rf_rdy_back", 32'(req_if.REQ_READY), 32'd1);
    idle();
    check("rf_actv",      32'(CMD), 32'(C_ACTV));
    check("rf_actv_addr", 32'(CMD_ADDR), 32'd9);
    check("rf_actv_bank", 32'(CMD_BANK), 32'd1);
    check("rf_mask2",     32'(OPEN_MASK), 32'h2);
    noops(2, "rf_trcd");
    idle();
    check("rf_wrte",      32'(CMD), 32'(C_WRTE));
    check("rf_wrte_addr", 32'(CMD_ADDR), 32'd6);
    check("rf_wr",        32'(RW_WRITE), 32'd1);

    // Reset between ACTV and READ
    idle();
    cyc(1'b1, mk_addr(13'd2, 2'd2, 10'd1), 1'b0, 1'b0);
    check("ra_ready", 32'(req_if.REQ_READY), 32'd1);
    idle();
    check("ra_actv", 32'(CMD), 32'(C_ACTV));
    check("ra_mask", 32'(OPEN_MASK), 32'h6);
    idle();
    check("ra_gap",  32'(CMD), 32'(C_NOOP));
    RST = 1'b0;
    idle();
    check("ra_cmd",   32'(CMD), 32'(C_NOOP));
    check("ra_mask0", 32'(OPEN_MASK), 32'h0);
    check("ra_strb",  32'(RW_STROBE), 32'd0);
    RST = 1'b1;
    noops(6, "ra_no_read");
    check("ra_mask_end", 32'(OPEN_MASK), 32'h0);
    check("ra_ready_end", 32'(req_if.REQ_READY), 32'd1);

    // Refresh with every bank closed goes straight to ARSR
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("rc_blocked", 32'(req_if.REQ_READY), 32'd0);
    idle();
    check("rc_arsr", 32'(CMD), 32'(C_ARSR));
    check("rc_mask", 32'(OPEN_MASK), 32'h0);
    for (int i = 0; i < 8; i++) begin
      idle();
      check("rc_trfc_rdy", 32'(req_if.REQ_READY), 32'd0);
    end
    idle();
    check("rc_rdy_back", 32'(req_if.REQ_READY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_bank_sequencer.md
# ddr_bank_sequencer

Parametrised DDR SDRAM command sequencer that replaces the single-open-page state/entry pair of the memory controller. It tracks one open row per bank, issues PRCH/ACTV/READ/WRTE/ARSR with programmable timing gaps, and services toggle-style refresh requests. It sits between the memory clients' request handshake and the registered command/address pins; the DQ/DQS datapath consumes its `RW_STROBE`/`RW_WRITE` pulse.

## Interface
- `ROW_W`, 13: row address bits. This is also the `CMD_ADDR` width, ≥11.
- `BANK_W`, 2: bank bits. `NBANK = 2**BANK_W`.
- `COL_W`, 10: column bits, ≤10.
- `T_RP`, 3: PRCH-to-next-command cycles, ≥1.
- `T_RCD`, 3: ACTV-to-READ/WRTE cycles, ≥1.
- `T_CCD`, 2: READ/WRTE-to-next-command cycles, ≥1.
- `T_RFC`, 10: ARSR-to-next-command cycles, ≥1.
- `CLK` in 1: clock. All logic on posedge.
- `RST` in 1: synchronous, active-low reset.
- `REQ_VALID` in 1: client request present.
- `REQ_READY` out 1: request accepted on `REQ_VALID && REQ_READY`.
- `REQ_ADDR` in `ROW_W+BANK_W+COL_W`: `{row, bank, col}`, MSB first.
- `REQ_WE` in 1: 1 = write, 0 = read.
- `REFRESH_STROBE` in 1: each toggle requests one refresh.
- `CMD` out 3: registered command.
- `CMD_ADDR` out `ROW_W`: registered address pins.
- `CMD_BANK` out `BANK_W`: registered bank pins.
- `RW_STROBE` out 1: high in the cycle `CMD` is READ or WRTE.
- `RW_WRITE` out 1: equals 1 with `RW_STROBE` for WRTE.
- `OPEN_MASK` out `NBANK`: bit b = bank b has an open row.

## Operation
- Command encoding (RAS,CAS,WE): NOOP=111, ACTV=011, READ=101, WRTE=100, PRCH=010, ARSR=001.
- State: IDLE, PRE, ACT, RW, REF_PRE, REF. A single wait counter gates every transition out of a state.
- `refresh_pending = ack ^ REFRESH_STROBE`. `ack` is loaded from `REFRESH_STROBE` when ARSR issues and at reset. Several toggles before service collapse into one refresh.
- `REQ_READY = (state==IDLE) && wait_done && !refresh_pending`. It is combinational, so refresh wins over a same-cycle request.
- When a request is accepted, address and WE are latched and a hit/miss decision is made against `open_row[bank]`:
  - Hit (bank open, row equal): go to RW.
  - Bank closed: go to ACT.
  - Row conflict: go to PRE. PRCH drives `CMD_ADDR[10]=0` and `CMD_BANK=bank`, then clears `OPEN_MASK[bank]`.
- ACT issues ACTV with `CMD_ADDR=row`. It sets `OPEN_MASK[bank]` and `open_row[bank]`.
- RW issues READ/WRTE with `CMD_ADDR` = column zero-extended and A10=0 (no auto-precharge). Then return to IDLE.
- When refresh is pending in IDLE:
  - If `OPEN_MASK != 0`: REF_PRE issues PRCH with A10=1 and clears all of `OPEN_MASK`.
  - Then REF issues ARSR and returns to IDLE.
- Every cycle without an issued command drives `CMD=NOOP`. `CMD_ADDR`/`CMD_BANK` hold their last value.
- Reset values: `CMD=NOOP`, `CMD_ADDR=0`, `CMD_BANK=0`, `RW_STROBE=0`, `RW_WRITE=0`, `OPEN_MASK=0`, state IDLE, wait done. `REQ_READY` is 1 in the first cycle after release unless the strobe toggles.
- Reset mid-sequence aborts the sequence immediately. It does not issue PRCH; open tracking is simply cleared.

## Timing
- A request accepted in cycle n issues its first command in cycle n+1.
- If a command issues in cycle c with gap T, the next command issues no earlier than c+T. `REQ_READY` may rise in cycle c+T−1, so back-to-back hits give one READ/WRTE every `T_CCD` cycles.
- Read/write latency from acceptance to the READ/WRTE command:
  - Hit: 1.
  - Closed bank: 1+`T_RCD`.
  - Row conflict: 1+`T_RP`+`T_RCD`.
- Refresh, measured from the toggle seen while IDLE and waiting ready:
  - Banks open: PRCH at +1, ARSR at +1+`T_RP`.
  - Banks closed: ARSR at +1.
  - `REQ_READY` returns `T_RFC`−1 cycles after ARSR.
- A strobe toggle while a request sequence is in flight is held. It is serviced after that sequence's RW gap.

## Structure
- Package `ddr_pkg`: command encoding constants, a state enum, and an address split helper (row/bank/col).
- Sub-module `ddr_bank_table`: `NBANK` × (valid, row) register file with lookup, set-one, clear-one and clear-all ports.

## Test plan
- Reset release, idle 20 cycles → `CMD` is NOOP throughout, `REQ_READY=1`, `OPEN_MASK=0`.
- Read row 5 bank 1 col 8 from reset → ACTV (addr 5, bank 1) at n+1; READ (addr 8) at n+4; `OPEN_MASK=0010`; `RW_STROBE` for 1 cycle.
- Three hits to row 5 bank 1 presented continuously → WRTE/READ spaced exactly 2 cycles apart with no ACTV.
- Conflict to row 9 bank 1 → PRCH (A10=0, bank 1) at n+1, ACTV at n+4, command at n+7.
- Toggle the strobe in the same cycle as `REQ_VALID` with bank 1 open → request not accepted; PRCH A10=1 then ARSR 3 cycles later; `OPEN_MASK=0`; request served after `T_RFC` as a closed-bank miss.
- Assert `RST` between ACTV and READ → next cycle `CMD=NOOP` and `OPEN_MASK=0`; no READ is issued.
